// File: rtl/pattern_gen.sv
// pattern_gen: host-programmable pattern playback engine.
// A small register block (CTRL/LEN/DIV/STATUS) plus a pattern RAM are mapped on a
// word-indexed host bus; a two-state FSM plays RAM entries out on dout/stb at a
// programmable rate. Loop mode (CTRL.LOOP) is compiled in only when the macro
// PATTERN_GEN_LOOP_EN is defined; otherwise every run is one-shot.
module pattern_gen #(
  parameter int unsigned LAW      = 10,
  parameter int unsigned DW       = 32,
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned RAM_DW   = 8,
  parameter int unsigned RAM_BASE = 'h100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LAW-1:0]    addr,
  input  logic [DW-1:0]     wdata,
  input  logic              we,
  output logic [DW-1:0]     rdata,
  output logic [RAM_DW-1:0] dout,
  output logic              stb,
  output logic              busy,
  output logic              done
);

  localparam int unsigned Depth = 2 ** RAM_AW;
  localparam int unsigned LenW  = RAM_AW + 1;
  localparam int unsigned DivW  = 16;

  localparam logic [LAW-1:0] AddrCtrl   = LAW'(0);
  localparam logic [LAW-1:0] AddrLen    = LAW'(1);
  localparam logic [LAW-1:0] AddrDiv    = LAW'(2);
  localparam logic [LAW-1:0] AddrStatus = LAW'(3);

  // RAM_BASE is aligned to the RAM depth, so the upper address bits select the RAM.
  localparam logic [LAW-RAM_AW-1:0] RamBaseHi = (LAW-RAM_AW)'(RAM_BASE >> RAM_AW);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e              state_q;
  logic [RAM_DW-1:0]   mem_q [Depth];
  logic [RAM_DW-1:0]   dout_q;
  logic                stb_q;
  logic                done_q;
  logic [DW-1:0]       rdata_q;
  logic [DW-1:0]       rdata_d;
  logic [LenW-1:0]     len_q;
  logic [DivW-1:0]     div_q;
  logic                loop_q;
  logic [LenW-1:0]     run_len_q;
  logic [DivW-1:0]     run_div_q;
  logic [RAM_AW-1:0]   ptr_q;
  logic [DivW-1:0]     cnt_q;

  logic                ram_sel;
  logic [RAM_AW-1:0]   ram_idx;
  logic                wr_ctrl;
  logic                wr_len;
  logic                wr_div;
  logic                wr_ram;
  logic                start_req;
  logic                stop_req;
  logic [LenW-1:0]     len_clamped;
  logic                last_entry;
  logic                unused_wdata;

  assign ram_sel = (addr[LAW-1:RAM_AW] == RamBaseHi);
  assign ram_idx = addr[RAM_AW-1:0];

  assign wr_ctrl = we && !ram_sel && (addr == AddrCtrl);
  assign wr_len  = we && !ram_sel && (addr == AddrLen);
  assign wr_div  = we && !ram_sel && (addr == AddrDiv);
  assign wr_ram  = we && ram_sel;

  // STOP has priority over START when both are written together.
  assign stop_req  = wr_ctrl && wdata[1];
  assign start_req = wr_ctrl && wdata[0] && !wdata[1];

  assign len_clamped = (len_q > LenW'(Depth)) ? LenW'(Depth) : len_q;
  assign last_entry  = (LenW'(ptr_q) == (run_len_q - LenW'(1)));

  // Not every wdata bit lands in a register.
  assign unused_wdata = ^wdata;

  // Pattern RAM: host writable at any time, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem_q[ram_idx] <= wdata[RAM_DW-1:0];
    end
  end

  // Host-visible configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q <= '0;
      div_q <= '0;
    end else begin
      if (wr_len) len_q <= wdata[LenW-1:0];
      if (wr_div) div_q <= wdata[DivW-1:0];
    end
  end

`ifdef PATTERN_GEN_LOOP_EN
  // Stored LOOP bit; START/STOP in the same write do not disturb it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      loop_q <= 1'b0;
    end else if (wr_ctrl) begin
      loop_q <= wdata[2];
    end
  end
`else
  assign loop_q = 1'b0;
`endif

  // Read mux: unmapped addresses and the write-pulse bits return zero.
  always_comb begin
    rdata_d = '0;
    if (ram_sel) begin
      rdata_d[RAM_DW-1:0] = mem_q[ram_idx];
    end else begin
      case (addr)
        AddrCtrl:   rdata_d[2] = loop_q;
        AddrLen:    rdata_d[LenW-1:0] = len_q;
        AddrDiv:    rdata_d[DivW-1:0] = div_q;
        AddrStatus: begin
          rdata_d[0]          = (state_q == StRun);
          rdata_d[RAM_AW+7:8] = ptr_q;
        end
        default: ;
      endcase
    end
  end

  // Registered read data, one cycle after the address is presented.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Playback FSM. The counter is preloaded with 1 at START so the first strobe
  // lands two edges after the START write; afterwards it reloads with DIV,
  // giving DIV+1 cycles between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dout_q    <= '0;
      stb_q     <= 1'b0;
      done_q    <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      run_len_q <= '0;
      run_div_q <= '0;
    end else begin
      stb_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_req && (len_q != '0)) begin
            state_q   <= StRun;
            ptr_q     <= '0;
            cnt_q     <= DivW'(1);
            run_len_q <= len_clamped;
            run_div_q <= div_q;
          end
        end
        StRun: begin
          if (stop_req) begin
            state_q <= StIdle;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DivW'(1);
          end else begin
            stb_q  <= 1'b1;
            dout_q <= mem_q[ptr_q];
            cnt_q  <= run_div_q;
            if (last_entry) begin
              if (loop_q) begin
                ptr_q <= '0;
              end else begin
                state_q <= StIdle;
                done_q  <= 1'b1;
              end
            end else begin
              ptr_q <= ptr_q + RAM_AW'(1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rdata = rdata_q;
  assign dout  = dout_q;
  assign stb   = stb_q;
  assign done  = done_q;
  assign busy  = (state_q == StRun);

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen: expected strobes (data, cycle, done flag)
// are queued when a run is started and popped by a monitor on every stb.
module tb_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [7:0]  dout;
  logic        stb;
  logic        busy;
  logic        done;

  pattern_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .dout  (dout),
    .stb   (stb),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    logic       last;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] mem_m [64];
  int         cyc = 0;
  int         wr_cyc;
  int         n_checks = 0;
  int         n_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (stb) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_stb", stb, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("dout", dout, e.data);
        check_eq("stb_cycle", cyc, e.cyc);
        check_eq("done_with_stb", done, e.last);
      end
    end else if (done) begin
      check_eq("spurious_done", done, 0);
    end
  end

  task automatic host_wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(negedge clk);
    we     = 1'b0;
    wr_cyc = cyc;
  endtask

  task automatic host_rd(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    we   = 1'b0;
    @(negedge clk);
    d = rdata;
  endtask

  task automatic push_run(input int c0, input int eff_len, input int div, input int n,
                          input bit loop);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.data = mem_m[k % eff_len];
      e.cyc  = c0 + 2 + k * (div + 1);
      e.last = !loop && (k == eff_len - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("idle_timeout", busy, 0);
  endtask

  initial begin
    logic [31:0] rd;
    int          seen;
    int          c0;

    rst_n = 1'b0;
    addr  = '0;
    wdata = '0;
    we    = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_stb", stb, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    host_rd(10'h3, rd);
    check_eq("rst_status", rd, 0);

    // Load the whole pattern RAM.
    for (int i = 0; i < 64; i++) mem_m[i] = 8'((i * 7 + 3) & 8'hff);
    mem_m[0] = 8'h11;
    mem_m[1] = 8'h22;
    mem_m[2] = 8'h33;
    mem_m[3] = 8'h44;
    for (int i = 0; i < 64; i++) host_wr(10'h100 + 10'(i), {24'h0, mem_m[i]});
    host_rd(10'h102, rd);
    check_eq("ram_rd2", rd, 32'h33);

    // LEN=4, DIV=0: back-to-back strobes, done with the fourth.
    host_wr(10'h1, 32'd4);
    host_wr(10'h2, 32'd0);
    host_wr(10'h0, 32'h1);
    push_run(wr_cyc, 4, 0, 4, 1'b0);
    check_eq("run1_busy", busy, 1);
    wait_idle(20);
    repeat (3) @(negedge clk);
    check_eq("run1_sb_empty", sb_q.size(), 0);
    check_eq("run1_busy_after", busy, 0);

    // LEN=3, DIV=2: stop after the second strobe.
    host_wr(10'h1, 32'd3);
    host_wr(10'h2, 32'd2);
    host_rd(10'h2, rd);
    check_eq("div_readback", rd, 2);
    host_wr(10'h0, 32'h1);
    push_run(wr_cyc, 3, 2, 2, 1'b0);
    seen = 0;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      if (stb) seen++;
    end
    check_eq("stop_seen2", seen, 2);
    host_wr(10'h0, 32'h2);
    check_eq("stop_busy", busy, 0);
    repeat (10) @(negedge clk);
    check_eq("stop_sb_empty", sb_q.size(), 0);

    // LEN=0: START ignored.
    host_wr(10'h1, 32'd0);
    host_wr(10'h0, 32'h1);
    check_eq("len0_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_eq("len0_busy_later", busy, 0);

    // LEN=100 clamps to the 64-entry RAM.
    host_wr(10'h1, 32'd100);
    host_rd(10'h1, rd);
    check_eq("len_readback", rd, 100);
    host_wr(10'h2, 32'd0);
    host_wr(10'h0, 32'h1);
    push_run(wr_cyc, 64, 0, 64, 1'b0);
    wait_idle(200);
    repeat (3) @(negedge clk);
    check_eq("len100_sb_empty", sb_q.size(), 0);

`ifdef PATTERN_GEN_LOOP_EN
    // Loop mode: alternate RAM[0], RAM[1] without done; START+STOP ends it.
    host_wr(10'h1, 32'd2);
    host_wr(10'h0, 32'h5);
    c0 = wr_cyc;
    push_run(c0, 2, 0, 40, 1'b1);
    seen = 0;
    for (int i = 0; i < 60 && seen < 10; i++) begin
      @(negedge clk);
      if (stb) seen++;
    end
    check_eq("loop_seen10", seen, 10);
    check_eq("loop_busy", busy, 1);
    host_wr(10'h0, 32'h3);
    check_eq("loop_stop_busy", busy, 0);
    sb_q.delete();
    repeat (5) @(negedge clk);
`else
    // Without loop support the LOOP bit is not stored.
    host_wr(10'h0, 32'h4);
    host_rd(10'h0, rd);
    check_eq("ctrl_loop_unimpl", rd, 0);
    c0 = 0;
`endif

    // Reset in the middle of a run aborts without strobe or done.
    host_wr(10'h1, 32'd8);
    host_wr(10'h2, 32'd3);
    host_wr(10'h0, 32'h1);
    check_eq("rstrun_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rstrun_busy_after", busy, 0);
    check_eq("rstrun_stb_after", stb, 0);
    repeat (10) @(negedge clk);
    check_eq("rstrun_busy_later", busy, 0);
    for (int i = 0; i < 4; i++) begin
      host_rd(10'h100 + 10'(i), rd);
      check_eq("rstrun_ram", rd, {24'h0, mem_m[i]});
    end
    host_rd(10'h1, rd);
    check_eq("rstrun_len", rd, 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Global guard against a hung run.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
